// File: rtl/knn_vote.sv
// knn_vote: majority-vote classifier for the k-NN sorter output.
// Walks ranks 0..K-1, tallies label votes, picks the winner with a nearest-rank tie-break.
module knn_vote #(
    parameter int K       = 10,
    parameter int IDX_W   = 8,
    parameter int LABEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [3:0]         sel,
    input  logic [IDX_W-1:0]   idx_in,
    output logic [IDX_W-1:0]   lbl_addr,
    input  logic [LABEL_W-1:0] lbl_rdata,
    output logic               busy,
    output logic               done,
    output logic [LABEL_W-1:0] class_out,
    output logic [3:0]         class_votes
);
    // state    | meaning
    // S_IDLE   | waiting for start; counters cleared when start is accepted
    // S_SCAN   | issuing ranks 0..K-1 on sel, accumulating the previous rank's label
    // S_DRAIN  | accumulating the label of the last issued rank
    // S_DECIDE | comparing one class per cycle against the best-so-far
    // S_FIN    | done pulse, result presented
    localparam int                 NCLASS    = 2**LABEL_W;
    localparam logic [3:0]         RANK_LAST = 4'(K-1);
    localparam logic [3:0]         UNSEEN    = 4'd15;
    localparam logic [LABEL_W-1:0] CLS_LAST  = LABEL_W'(NCLASS-1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DECIDE, S_FIN} state_t;

    state_t             state, state_nxt;
    logic [3:0]         rank, rank_d;
    logic               lbl_vld;
    logic [LABEL_W-1:0] cls;
    logic [3:0]         votes      [NCLASS];
    logic [3:0]         first_rank [NCLASS];
    logic [3:0]         best_votes, best_first, best_votes_nxt, best_first_nxt;
    logic [LABEL_W-1:0] best_cls, best_cls_nxt;
    logic               take;
    logic               accept;

    assign accept   = (state == S_IDLE) && start;
    assign lbl_addr = idx_in;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SCAN;
            S_SCAN:   if (rank == RANK_LAST) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_DECIDE;
            S_DECIDE: if (cls == CLS_LAST) state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sel  = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_SCAN: begin
                sel  = rank;
                busy = 1'b1;
            end
            S_DRAIN, S_DECIDE: busy = 1'b1;
            S_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // rank_d tracks the rank whose label arrives next cycle from the synchronous memory
    always_ff @(posedge clk) begin
        if (rst) begin
            rank    <= '0;
            rank_d  <= '0;
            lbl_vld <= 1'b0;
            cls     <= '0;
        end else begin
            lbl_vld <= (state == S_SCAN);
            rank_d  <= rank;
            if (accept)
                rank <= '0;
            else if (state == S_SCAN)
                rank <= rank + 4'd1;
            if (state == S_DRAIN)
                cls <= '0;
            else if (state == S_DECIDE)
                cls <= cls + LABEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            for (int c = 0; c < NCLASS; c++) begin
                votes[c]      <= '0;
                first_rank[c] <= UNSEEN;
            end
        end else if (lbl_vld) begin
            votes[lbl_rdata] <= votes[lbl_rdata] + 4'd1;
            if (first_rank[lbl_rdata] == UNSEEN)
                first_rank[lbl_rdata] <= rank_d;
        end
    end

    // Equal non-zero counts go to the class whose first vote came from the nearer rank
    always_comb begin
        take = (votes[cls] > best_votes) ||
               ((votes[cls] == best_votes) && (votes[cls] != 4'd0) &&
                (first_rank[cls] < best_first));
        best_votes_nxt = take ? votes[cls]      : best_votes;
        best_first_nxt = take ? first_rank[cls] : best_first;
        best_cls_nxt   = take ? cls             : best_cls;
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            best_votes <= '0;
            best_first <= UNSEEN;
            best_cls   <= '0;
        end else if (state == S_DECIDE) begin
            best_votes <= best_votes_nxt;
            best_first <= best_first_nxt;
            best_cls   <= best_cls_nxt;
        end
    end

    // Loaded with the final comparison so the result is already valid during the done cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            class_out   <= '0;
            class_votes <= '0;
        end else if ((state == S_DECIDE) && (cls == CLS_LAST)) begin
            class_out   <= best_cls_nxt;
            class_votes <= best_votes_nxt;
        end
    end
endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: K=10 instance for the main vectors, K=1 instance for the single-neighbour case.
module tb_knn_vote;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [3:0] sel_a, sel_b;
    logic [7:0] idx_a, idx_b, addr_a, addr_b;
    logic [3:0] rdata_a, rdata_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [3:0] cls_a, cls_b, votes_a, votes_b;
    logic [3:0] lbl_mem [256];
    int         cyc = 0;
    int         t0 = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic [3:0] cls;
        logic [3:0] votes;
        int         at;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sorter model: rank r maps to training index r*13+5
    assign idx_a = 8'(sel_a) * 8'd13 + 8'd5;
    assign idx_b = 8'(sel_b) * 8'd13 + 8'd5;
    always @(posedge clk) rdata_a <= lbl_mem[addr_a];
    always @(posedge clk) rdata_b <= lbl_mem[addr_b];

    knn_vote #(.K(10), .IDX_W(8), .LABEL_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sel(sel_a), .idx_in(idx_a),
        .lbl_addr(addr_a), .lbl_rdata(rdata_a), .busy(busy_a), .done(done_a),
        .class_out(cls_a), .class_votes(votes_a)
    );

    knn_vote #(.K(1), .IDX_W(8), .LABEL_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sel(sel_b), .idx_in(idx_b),
        .lbl_addr(addr_b), .lbl_rdata(rdata_b), .busy(busy_b), .done(done_b),
        .class_out(cls_b), .class_votes(votes_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done_queue", q_a.size(), 1);
            end else begin
                ea = q_a.pop_front();
                check("a_class_out", cls_a, ea.cls);
                check("a_class_votes", votes_a, ea.votes);
                check("a_done_cycle", cyc, ea.at);
                check("a_busy_at_done", busy_a, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_done_queue", q_b.size(), 1);
            end else begin
                eb = q_b.pop_front();
                check("b_class_out", cls_b, eb.cls);
                check("b_class_votes", votes_b, eb.votes);
                check("b_done_cycle", cyc, eb.at);
            end
        end
    end

    task automatic load(input logic [39:0] labs);
        for (int r = 0; r < 10; r++)
            lbl_mem[8'(r * 13 + 5)] = labs[4*(9-r) +: 4];
    endtask

    task automatic wait_cyc(input int n);
        while (cyc - t0 < n) @(negedge clk);
    endtask

    task automatic start_a_run(input logic [39:0] labs, input logic [3:0] ec, input logic [3:0] ev);
        load(labs);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        q_a.push_back('{ec, ev, t0 + 28});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while (q_a.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("a_timeout_pending", q_a.size(), 0);
        q_a.delete();
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 256; i++) lbl_mem[i] = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_a_busy", busy_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_a_sel", sel_a, 0);
        check("rst_a_class_out", cls_a, 0);
        check("rst_a_class_votes", votes_a, 0);
        check("rst_a_lbl_addr", addr_a, idx_a);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_class_out", cls_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // unanimous 3, with ignored start pulses in cycles 3 and 20
        load(40'h3333333333);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        q_a.push_back('{4'd3, 4'd10, t0 + 28});
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_cycle1", busy_a, 1);
        for (int n = 1; n <= 10; n++) begin
            wait_cyc(n);
            check("a_sel_seq", sel_a, n - 1);
            check("a_lbl_addr", addr_a, 8'(n - 1) * 8'd13 + 8'd5);
            if (n == 3) start_a = 1'b1;
            if (n == 4) start_a = 1'b0;
        end
        wait_cyc(11);
        check("a_sel_drain", sel_a, 0);
        wait_cyc(20);
        start_a = 1'b1;
        wait_cyc(21);
        start_a = 1'b0;
        // start held through FIN into IDLE, next labels a clear majority of class 2
        wait_cyc(28);
        start_a = 1'b1;
        load(40'h1225212721);
        wait_cyc(29);
        check("a_idle_after_fin_busy", busy_a, 0);
        check("a_idle_after_fin_done", done_a, 0);
        check("a_held_class_out", cls_a, 3);
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        q_a.push_back('{4'd2, 4'd5, t0 + 28});
        @(negedge clk);
        start_a = 1'b0;
        wait_a();

        // tie of 4 and 6 at three votes each, nearest rank decides
        start_a_run(40'h4664994600, 4'd4, 4'd3);
        wait_a();
        start_a_run(40'h6464994600, 4'd6, 4'd3);
        wait_a();

        // reset in cycle 12 aborts the vote
        load(40'h5555555555);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(12);
        rst = 1'b1;
        wait_cyc(13);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_class_out", cls_a, 0);
        check("abort_class_votes", votes_a, 0);
        check("abort_sel", sel_a, 0);
        rst = 1'b0;
        start_a_run(40'h8888888888, 4'd8, 4'd10);
        wait_a();

        // K=1 instance, single neighbour labelled 15
        lbl_mem[5] = 4'd15;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        q_b.push_back('{4'd15, 4'd1, t0 + 19});
        @(negedge clk);
        start_b = 1'b0;
        check("b_sel_rank0", sel_b, 0);
        check("b_busy_cycle1", busy_b, 1);
        begin
            int n = 0;
            while (q_b.size() != 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        check("b_timeout_pending", q_b.size(), 0);
        @(negedge clk);
        check("b_idle_after", busy_b, 0);
        check("a_stays_idle", busy_a, 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
